// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared definitions for the mem_dma block-move engine.
//   - FSM state encodings (ST_IDLE, ST_RD, ST_WR)
//   - RAM data and address widths
//   - addr_inc(): modulo-2^16 word-address increment
package mem_dma_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10
    } state_t;

    // Wraps silently from 0xFFFF to 0x0000.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mem_dma_ctr.sv
// mem_dma_ctr: address and word counters for mem_dma.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                latch src_in/dst_in/len_in, clear count
//   step                advance one word: src+1, dst+1, rem-1, count+1
//   src_in, dst_in      start addresses
//   len_in              word count to move
//   dst                 current destination address
//   src_next, dst_next  addresses of the following word (wrapping)
//   count               words written so far
//   last                remaining-word counter equals 1
module mem_dma_ctr
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] src_next,
    output logic [ADDR_W-1:0] dst_next,
    output logic [LEN_W-1:0]  count,
    output logic              last
);

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  rem_r;
    logic [LEN_W-1:0]  count_r;

    // Counter registers: load at start, step once per completed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r   <= {ADDR_W{1'b0}};
            dst_r   <= {ADDR_W{1'b0}};
            rem_r   <= LEN_ZERO;
            count_r <= LEN_ZERO;
        end else if (load) begin
            src_r   <= src_in;
            dst_r   <= dst_in;
            rem_r   <= len_in;
            count_r <= LEN_ZERO;
        end else if (step) begin
            src_r   <= addr_inc(src_r);
            dst_r   <= addr_inc(dst_r);
            rem_r   <= rem_r - LEN_ONE;
            count_r <= count_r + LEN_ONE;
        end else begin
            src_r   <= src_r;
            dst_r   <= dst_r;
            rem_r   <= rem_r;
            count_r <= count_r;
        end
    end

    assign dst      = dst_r;
    assign src_next = addr_inc(src_r);
    assign dst_next = addr_inc(dst_r);
    assign count    = count_r;
    assign last     = (rem_r == LEN_ONE);

endmodule

// File: rtl/mem_dma.sv
// mem_dma: single-word-at-a-time block copy engine driving a synchronous RAM port.
// Configuration macro: MEM_DMA_FILL_EN adds a fill mode (i_fill, i_fill_val) that
// writes a constant at one word per cycle without reading.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start, i_abort      start request (IDLE only), stop after current cycle
//   i_src, i_dst, i_len   transfer parameters, sampled at start
//   o_ce, o_we, o_addr    RAM control/address (registered)
//   o_w_data              RAM write data (combinational from i_r_data in WR)
//   i_r_data              RAM read data, one cycle after the read address
//   o_busy, o_done        in RD/WR, one-cycle end-of-transfer pulse
//   o_count               words written in the current/last transfer
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
`ifdef MEM_DMA_FILL_EN
    input  logic              i_fill,
    input  logic [DATA_W-1:0] i_fill_val,
`endif
    output logic              o_ce,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_w_data,
    input  logic [DATA_W-1:0] i_r_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_count
);

    state_t            state_r;
    logic              ce_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic              busy_r;
    logic              done_r;
    logic              load_s;
    logic              step_s;
    logic [ADDR_W-1:0] dst_s;
    logic [ADDR_W-1:0] src_next_s;
    logic [ADDR_W-1:0] dst_next_s;
    logic              last_s;
    logic [DATA_W-1:0] w_data_s;
`ifdef MEM_DMA_FILL_EN
    logic              fill_r;
    logic [DATA_W-1:0] fill_val_r;
`endif

    // Abort beats start in IDLE; a zero-length start still loads (clears o_count).
    assign load_s = (state_r == ST_IDLE) && i_start && !i_abort;
    assign step_s = (state_r == ST_WR);

    mem_dma_ctr #(.LEN_W(LEN_W)) u_ctr (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (load_s),
        .step     (step_s),
        .src_in   (i_src),
        .dst_in   (i_dst),
        .len_in   (i_len),
        .dst      (dst_s),
        .src_next (src_next_s),
        .dst_next (dst_next_s),
        .count    (o_count),
        .last     (last_s)
    );

    // Control FSM; bus outputs are computed for the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            ce_r    <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef MEM_DMA_FILL_EN
            fill_r     <= 1'b0;
            fill_val_r <= {DATA_W{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        if (i_len == {LEN_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b1;
                            ce_r   <= 1'b1;
`ifdef MEM_DMA_FILL_EN
                            fill_r     <= i_fill;
                            fill_val_r <= i_fill_val;
                            if (i_fill) begin
                                state_r <= ST_WR;
                                we_r    <= 1'b1;
                                addr_r  <= i_dst;
                            end else begin
                                state_r <= ST_RD;
                                we_r    <= 1'b0;
                                addr_r  <= i_src;
                            end
`else
                            state_r <= ST_RD;
                            we_r    <= 1'b0;
                            addr_r  <= i_src;
`endif
                        end
                    end
                end
                ST_RD: begin
                    if (i_abort) begin
                        // Read is discarded; no write follows.
                        state_r <= ST_IDLE;
                        ce_r    <= 1'b0;
                        we_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WR;
                        we_r    <= 1'b1;
                        addr_r  <= dst_s;
                    end
                end
                ST_WR: begin
                    if (i_abort || last_s) begin
                        state_r <= ST_IDLE;
                        ce_r    <= 1'b0;
                        we_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
`ifdef MEM_DMA_FILL_EN
                        if (fill_r) begin
                            addr_r <= dst_next_s;
                        end else begin
                            state_r <= ST_RD;
                            we_r    <= 1'b0;
                            addr_r  <= src_next_s;
                        end
`else
                        state_r <= ST_RD;
                        we_r    <= 1'b0;
                        addr_r  <= src_next_s;
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ce_r    <= 1'b0;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Write data: RAM read latency is one cycle, so pass i_r_data straight through in WR.
    always_comb begin
        w_data_s = {DATA_W{1'b0}};
        if (state_r == ST_WR) begin
`ifdef MEM_DMA_FILL_EN
            if (fill_r) begin
                w_data_s = fill_val_r;
            end else begin
                w_data_s = i_r_data;
            end
`else
            w_data_s = i_r_data;
`endif
        end else begin
            w_data_s = {DATA_W{1'b0}};
        end
    end

    assign o_ce     = ce_r;
    assign o_we     = we_r;
    assign o_addr   = addr_r;
    assign o_w_data = w_data_s;
    assign o_busy   = busy_r;
    assign o_done   = done_r;

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: self-checking bench for mem_dma with a 1024-word synchronous RAM model.
// Expected bus traces, memory contents, counts and latencies come from a word-by-word
// copy model over a shadow memory array.
module tb_mem_dma;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_src;
    logic [15:0] i_dst;
    logic [15:0] i_len;
    logic        o_ce;
    logic        o_we;
    logic [15:0] o_addr;
    logic [15:0] o_w_data;
    logic [15:0] r_data;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;
`ifdef MEM_DMA_FILL_EN
    logic        i_fill;
    logic [15:0] i_fill_val;
`endif

    logic [15:0] mem     [0:1023];
    logic [15:0] exp_mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_addr;
    logic [15:0] pre_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_dma dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_src    (i_src),
        .i_dst    (i_dst),
        .i_len    (i_len),
`ifdef MEM_DMA_FILL_EN
        .i_fill   (i_fill),
        .i_fill_val(i_fill_val),
`endif
        .o_ce     (o_ce),
        .o_we     (o_we),
        .o_addr   (o_addr),
        .o_w_data (o_w_data),
        .i_r_data (r_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_count  (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read and write, 1024 words, address wraps on low 10 bits.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (o_ce && o_we) begin
            mem[o_addr[9:0]] <= o_w_data;
        end
        if (o_ce && !o_we) begin
            r_data <= mem[o_addr[9:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("note %s: first differing word at %0h", nm, first);
        chk({nm, "_mem"}, 32'(bad), 32'd0);
    endtask

    // Run one copy; ab_wr/ab_rd (1-based, 0 = none) pick the WR/RD cycle to abort in.
    task automatic run_xfer(input string nm, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input int ab_wr, input int ab_rd,
                            input int exp_cnt, input int exp_cyc);
        logic [16:0] exp_q[$];
        logic [16:0] act_q[$];
        logic [15:0] a;
        logic [15:0] b;
        int wr_seen = 0;
        int rd_seen = 0;
        int done_idx = -1;
        int bad = 0;
        // Reference: ascending word-by-word copy, reads see earlier writes.
        for (int i = 0; i < exp_cnt; i++) begin
            a = s + 16'(i);
            b = d + 16'(i);
            exp_q.push_back({1'b0, a});
            exp_q.push_back({1'b1, b});
            exp_mem[b[9:0]] = exp_mem[a[9:0]];
        end
        if (ab_rd > 0) begin
            a = s + 16'(ab_rd - 1);
            exp_q.push_back({1'b0, a});
        end
        @(negedge clk);
        i_src = s; i_dst = d; i_len = n; i_start = 1'b1;
        for (int idx = 0; idx < 100; idx++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = 1'b0;
            i_src = 16'($urandom); i_dst = 16'($urandom); i_len = 16'($urandom_range(0, 9));
            if (o_ce) act_q.push_back({o_we, o_addr});
            if (o_ce && o_we) begin
                wr_seen++;
                if (wr_seen == ab_wr) i_abort = 1'b1;
            end else if (o_ce) begin
                rd_seen++;
                if (rd_seen == ab_rd) i_abort = 1'b1;
            end
            if (idx == 1 && o_busy) i_start = 1'b1;
            if (o_done) begin
                done_idx = idx;
                chk({nm, "_ce_at_done"}, 32'(o_ce), 32'd0);
                break;
            end
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        chk({nm, "_done_seen"}, 32'(done_idx >= 0), 32'd1);
        chk({nm, "_cycles"}, 32'(done_idx), 32'(exp_cyc));
        chk({nm, "_count"}, 32'(o_count), 32'(exp_cnt));
        chk({nm, "_busy"}, 32'(o_busy), 32'd0);
        if (act_q.size() != exp_q.size()) bad = 1000;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (act_q[i] !== exp_q[i]) bad++;
        chk({nm, "_trace"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({nm, "_quiet_after"}, 32'({o_ce, o_done}), 32'd0);
        check_mem(nm);
    endtask

    typedef struct {
        string       nm;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        int          ab_wr;
        int          ab_rd;
        int          exp_cnt;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int k;
        int sel;
        int wr_seen;
        int rd_seen;
        int seen;
        logic [15:0] s;
        logic [15:0] d;

        vecs[0] = '{"copy4",   16'h0010, 16'h0200, 16'd4, 0, 0, 4, 8};
        vecs[1] = '{"zero",    16'h0020, 16'h0220, 16'd0, 0, 0, 0, 0};
        vecs[2] = '{"wrap",    16'hFFFE, 16'h0100, 16'd3, 0, 0, 3, 6};
        vecs[3] = '{"abt_wr3", 16'h0040, 16'h0240, 16'd8, 3, 0, 3, 6};
        vecs[4] = '{"abt_rd2", 16'h0060, 16'h0260, 16'd5, 0, 2, 1, 3};
        vecs[5] = '{"overlap", 16'h0080, 16'h0081, 16'd4, 0, 0, 4, 8};

        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_src = 16'h0000; i_dst = 16'h0000; i_len = 16'h0000;
        pre_en = 1'b0; pre_addr = 10'd0; pre_data = 16'h0000;
`ifdef MEM_DMA_FILL_EN
        i_fill = 1'b0; i_fill_val = 16'h0000;
`endif
        // Preload RAM and shadow model while reset is held.
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            pre_en = 1'b1; pre_addr = 10'(i); pre_data = 16'($urandom);
            exp_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_en = 1'b0;
        chk("rst_ctl", 32'({o_ce, o_we, o_busy, o_done}), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].nm, vecs[v].src, vecs[v].dst, vecs[v].len,
                     vecs[v].ab_wr, vecs[v].ab_rd, vecs[v].exp_cnt, vecs[v].exp_cyc);

        // Abort together with start in IDLE: start dropped, nothing happens.
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1; i_len = 16'd4; i_src = 16'h0300; i_dst = 16'h0310;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_ce || o_done || o_busy) seen++;
            @(negedge clk);
        end
        chk("start_abort_idle", 32'(seen), 32'd0);

        // Randomized transfers against the copy model.
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 10);
            s = 16'($urandom);
            d = 16'($urandom);
            sel = (n == 0) ? 3 : $urandom_range(0, 3);
            k = (n == 0) ? 0 : $urandom_range(1, n);
            if (sel == 0)      run_xfer("rnd_abwr", s, d, 16'(n), k, 0, k, 2 * k);
            else if (sel == 1) run_xfer("rnd_abrd", s, d, 16'(n), 0, k, k - 1, 2 * k - 1);
            else               run_xfer("rnd", s, d, 16'(n), 0, 0, n, 2 * n);
        end

        // Reset asserted during the 2nd RD: outputs drop at once, first word kept.
        exp_mem[10'h140] = exp_mem[10'h0C0];
        @(negedge clk);
        i_src = 16'h00C0; i_dst = 16'h0140; i_len = 16'd8; i_start = 1'b1;
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_ce && !o_we) rd_seen++;
            if (rd_seen == 2) break;
        end
        chk("rst_mid_reached_rd2", 32'(rd_seen), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 32'({o_ce, o_we, o_busy, o_done}), 32'd0);
        chk("rst_mid_count", 32'(o_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", 32'({o_ce, o_busy}), 32'd0);
        check_mem("rst_mid");
        run_xfer("post_rst", 16'h0005, 16'h0390, 16'd2, 0, 0, 2, 4);

`ifdef MEM_DMA_FILL_EN
        for (int i = 0; i < 5; i++) exp_mem[10'h300 + 10'(i)] = 16'hBEEF;
        @(negedge clk);
        i_fill = 1'b1; i_fill_val = 16'hBEEF; i_dst = 16'h0300; i_len = 16'd5; i_start = 1'b1;
        wr_seen = 0; rd_seen = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_ce && o_we) wr_seen++;
            else if (o_ce) rd_seen++;
            if (o_done) begin seen = 1; break; end
        end
        i_fill = 1'b0;
        chk("fill_done", 32'(seen), 32'd1);
        chk("fill_wr", 32'(wr_seen), 32'd5);
        chk("fill_rd", 32'(rd_seen), 32'd0);
        chk("fill_count", 32'(o_count), 32'd5);
        @(negedge clk);
        check_mem("fill");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
